if_id_pipe_reg: RTL and testbench
=================================

Name: if_id_pipe_reg

Overview:
- IF/ID pipeline boundary register, directly downstream of the fetch stage.
- Captures the fetched instruction and PC+2 each cycle and presents them to decode.
- Holds its contents on hazard stalls and injects NOP bubbles on branch, jump, exception and RTI redirects.
- Detects a fetched HALT, drives the fetch-stage halt input, and keeps a saturating stall-cycle counter for performance debug.

Parameters:
- NOP_INSTR, 16'h0800, bubble encoding driven on id_instr when the stage holds no valid instruction.
- HALT_OPC, 5'b00000, opcode field (instr[15:11]) that identifies HALT.
- FLUSH_BUBBLES, 1, number of extra bubble cycles inserted after a flush cycle; range 0..3.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- if_PC2  in  16  PC+2 from fetch.
- if_instr  in  16  instruction word from fetch.
- stall  in  1  hazard-unit stall: hold current contents.
- flush  in  1  redirect (branch_or_jump | exception | RTI) resolved downstream: kill the stage.
- id_PC2  out  16  registered PC+2 to decode.
- id_instr  out  16  registered instruction, or NOP_INSTR when id_valid=0.
- id_valid  out  1  stage holds a real instruction.
- halt_fetched  out  1  to fetch halt input: a HALT is latched, freeze the PC.
- stall_cnt  out  16  saturating count of cycles spent in HOLD.

Behaviour:
- Reset (rst=0, asynchronous, effective any cycle):
  - id_PC2=0, id_instr=NOP_INSTR, id_valid=0, halt_fetched=0, stall_cnt=0.
  - state=BUBBLE, bubble counter=0.
  - First real capture occurs on the first rising edge after rst deasserts.
- State register: RUN, HOLD, BUBBLE, HALTED.
- Per-edge priority: flush > stall > halt detect > normal capture.
- flush=1, any state:
  - Next state BUBBLE; id_valid=0, id_instr=NOP_INSTR.
  - Bubble counter loads FLUSH_BUBBLES; halt_fetched clears.
- BUBBLE:
  - Counter nonzero and stall=0: decrement, stay BUBBLE, output NOP.
  - Counter zero and stall=0: capture if_* and go RUN (or HALTED if HALT).
  - stall=1: counter and outputs frozen.
- RUN, stall=0:
  - Capture if_PC2 and if_instr; id_valid=1.
  - If if_instr[15:11]==HALT_OPC, go HALTED, else stay RUN.
- RUN, stall=1: go HOLD; outputs unchanged.
- HOLD:
  - Outputs frozen; stall_cnt increments each cycle in HOLD, saturating at 16'hFFFF.
  - stall=0 returns to RUN with a normal capture on that same edge.
- HALTED:
  - halt_fetched=1 (registered, asserted the cycle after HALT capture); contents frozen; stall ignored.
  - Only flush or reset leaves HALTED.
- Latency: if_* to id_* is exactly one cycle when not stalled or bubbling.
- Simultaneous events:
  - flush and stall together: flush wins; the stage empties.
  - flush on the HALT capture edge: no HALTED entry.
- halt_fetched is a registered function of state (==HALTED); no combinational path from if_instr.
- stall_cnt is never cleared by flush, only by reset.

Test Plan:
- Reset mid-run: drive rst low asynchronously between edges with id_valid=1 -> outputs go to 0 / 16'h0800 / 0 immediately, without waiting for a clock edge.
- Normal flow: if_instr=16'hC005, if_PC2=16'h0004, then 16'hC106 / 16'h0006 -> id_* match each one cycle later, id_valid=1.
- Stall 3 cycles holding 16'hC005 while if_instr changes -> id_instr stays 16'hC005; stall_cnt=3; capture resumes on the release edge.
- Flush with FLUSH_BUBBLES=1 -> id_instr=16'h0800 and id_valid=0 for 2 cycles, then the next fetched instruction appears; flush plus stall together -> the stage still empties.
- HALT 16'h0000 captured -> halt_fetched=1 next cycle and stays high through 5 cycles of changing if_instr; a flush then clears it.
- Saturation: hold stall for 65540 cycles -> stall_cnt=16'hFFFF, no wrap.

Source files
------------

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - IF/ID pipeline register with stall hold, flush bubbles and HALT latch
module if_id_pipe_reg #(
    parameter logic [15:0] NOP_INSTR     = 16'h0800,
    parameter logic [4:0]  HALT_OPC      = 5'b00000,
    parameter int unsigned FLUSH_BUBBLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] if_PC2,
    input  logic [15:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    output logic [15:0] id_PC2,
    output logic [15:0] id_instr,
    output logic        id_valid,
    output logic        halt_fetched,
    output logic [15:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        HOLD   = 2'd1,
        BUBBLE = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] BUBBLE_LOAD = 2'(FLUSH_BUBBLES);

    state_t      state_q, state_d;
    logic [1:0]  bub_cnt_q, bub_cnt_d;
    logic [15:0] pc2_q, pc2_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;
    logic        halt_q, halt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic        capture;

    always_comb begin
        state_d     = state_q;
        bub_cnt_d   = bub_cnt_q;
        pc2_d       = pc2_q;
        instr_d     = instr_q;
        valid_d     = valid_q;
        stall_cnt_d = stall_cnt_q;
        capture     = 1'b0;

        // HOLD cycles are counted regardless of what ends them
        if (state_q == HOLD && stall_cnt_q != 16'hFFFF)
            stall_cnt_d = stall_cnt_q + 16'd1;

        if (flush) begin
            state_d   = BUBBLE;
            valid_d   = 1'b0;
            instr_d   = NOP_INSTR;
            bub_cnt_d = BUBBLE_LOAD;
        end else begin
            case (state_q)
                RUN: begin
                    if (stall) state_d = HOLD;
                    else       capture = 1'b1;
                end
                HOLD: begin
                    if (!stall) capture = 1'b1;
                end
                BUBBLE: begin
                    if (!stall) begin
                        if (bub_cnt_q != 2'd0) bub_cnt_d = bub_cnt_q - 2'd1;
                        else                   capture   = 1'b1;
                    end
                end
                default: ;
            endcase

            if (capture) begin
                pc2_d   = if_PC2;
                instr_d = if_instr;
                valid_d = 1'b1;
                state_d = (if_instr[15:11] == HALT_OPC) ? HALTED : RUN;
            end
        end

        halt_d = (state_d == HALTED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BUBBLE;
            bub_cnt_q   <= 2'd0;
            pc2_q       <= 16'd0;
            instr_q     <= NOP_INSTR;
            valid_q     <= 1'b0;
            halt_q      <= 1'b0;
            stall_cnt_q <= 16'd0;
        end else begin
            state_q     <= state_d;
            bub_cnt_q   <= bub_cnt_d;
            pc2_q       <= pc2_d;
            instr_q     <= instr_d;
            valid_q     <= valid_d;
            halt_q      <= halt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign id_PC2       = pc2_q;
    assign id_instr     = instr_q;
    assign id_valid     = valid_q;
    assign halt_fetched = halt_q;
    assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// tb/tb_if_id_pipe_reg.sv - scoreboard bench for if_id_pipe_reg
module tb_if_id_pipe_reg;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] if_PC2, if_instr;
    logic        stall, flush;
    logic [15:0] id_PC2, id_instr, stall_cnt;
    logic        id_valid, halt_fetched;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] pc;
        logic [15:0] instr;
        logic        valid;
        logic        halt;
        logic [15:0] cnt;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    if_id_pipe_reg dut (
        .clk          (clk),
        .rst          (rst_n),
        .if_PC2       (if_PC2),
        .if_instr     (if_instr),
        .stall        (stall),
        .flush        (flush),
        .id_PC2       (id_PC2),
        .id_instr     (id_instr),
        .id_valid     (id_valid),
        .halt_fetched (halt_fetched),
        .stall_cnt    (stall_cnt)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected post-edge state, then compare.
    task automatic step(input logic [15:0] pc, input logic [15:0] ins, input logic st, input logic fl,
                        input logic ev, input logic [15:0] ei, input logic [15:0] ep,
                        input logic eh, input logic [15:0] ec, input string tag);
        exp_t e;
        if_PC2   = pc;
        if_instr = ins;
        stall    = st;
        flush    = fl;
        e.pc = ep; e.instr = ei; e.valid = ev; e.halt = eh; e.cnt = ec;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check_eq({tag, ".valid"}, 32'(id_valid), 32'(e.valid));
        check_eq({tag, ".instr"}, 32'(id_instr), 32'(e.instr));
        if (e.valid) check_eq({tag, ".pc2"}, 32'(id_PC2), 32'(e.pc));
        check_eq({tag, ".halt"}, 32'(halt_fetched), 32'(e.halt));
        check_eq({tag, ".cnt"}, 32'(stall_cnt), 32'(e.cnt));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; if_PC2 = 16'h0; if_instr = 16'hFFFF; stall = 1'b0; flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst.pc2",   32'(id_PC2), 32'h0);
        check_eq("rst.instr", 32'(id_instr), 32'h0800);
        check_eq("rst.valid", 32'(id_valid), 32'h0);
        check_eq("rst.halt",  32'(halt_fetched), 32'h0);
        check_eq("rst.cnt",   32'(stall_cnt), 32'h0);
        rst_n = 1'b1;

        // normal flow: first edge after reset captures
        step(16'h0004, 16'hC005, 0, 0, 1, 16'hC005, 16'h0004, 0, 16'd0, "run0");
        step(16'h0006, 16'hC106, 0, 0, 1, 16'hC106, 16'h0006, 0, 16'd0, "run1");
        step(16'h0004, 16'hC005, 0, 0, 1, 16'hC005, 16'h0004, 0, 16'd0, "run2");

        // three stalled cycles then release
        step(16'h0008, 16'hC207, 1, 0, 1, 16'hC005, 16'h0004, 0, 16'd0, "stl0");
        step(16'h000A, 16'hC308, 1, 0, 1, 16'hC005, 16'h0004, 0, 16'd1, "stl1");
        step(16'h000C, 16'hC409, 1, 0, 1, 16'hC005, 16'h0004, 0, 16'd2, "stl2");
        step(16'h000E, 16'hC50A, 0, 0, 1, 16'hC50A, 16'h000E, 0, 16'd3, "stlrel");

        // flush: two NOP cycles, then capture
        step(16'h0010, 16'hC60B, 0, 1, 0, 16'h0800, 16'h0000, 0, 16'd3, "fl0");
        step(16'h0012, 16'hC70C, 0, 0, 0, 16'h0800, 16'h0000, 0, 16'd3, "fl1");
        step(16'h0014, 16'hC80D, 0, 0, 1, 16'hC80D, 16'h0014, 0, 16'd3, "fl2");

        // flush with stall: still empties; stall in BUBBLE freezes bubble counter
        step(16'h0016, 16'hC90E, 1, 1, 0, 16'h0800, 16'h0000, 0, 16'd3, "fs0");
        step(16'h0018, 16'hCA0F, 1, 0, 0, 16'h0800, 16'h0000, 0, 16'd3, "fs1");
        step(16'h001A, 16'hCB10, 0, 0, 0, 16'h0800, 16'h0000, 0, 16'd3, "fs2");
        step(16'h001C, 16'hCC11, 0, 0, 1, 16'hCC11, 16'h001C, 0, 16'd3, "fs3");

        // HALT capture, frozen for five cycles of changing input, then flush clears it
        step(16'h001E, 16'h0000, 0, 0, 1, 16'h0000, 16'h001E, 1, 16'd3, "hlt");
        for (int i = 0; i < 5; i++)
            step(16'h0100 + 16'(i), 16'hC000 + 16'(i), logic'(i % 2), 0,
                 1, 16'h0000, 16'h001E, 1, 16'd3, "hltfrz");
        step(16'h0020, 16'hC005, 0, 1, 0, 16'h0800, 16'h0000, 0, 16'd3, "hltfl0");
        step(16'h0022, 16'hC106, 0, 0, 0, 16'h0800, 16'h0000, 0, 16'd3, "hltfl1");
        step(16'h0024, 16'hC207, 0, 0, 1, 16'hC207, 16'h0024, 0, 16'd3, "hltfl2");

        // flush on the HALT capture edge: no HALTED entry
        step(16'h0026, 16'h0000, 0, 1, 0, 16'h0800, 16'h0000, 0, 16'd3, "hfl0");
        step(16'h0028, 16'hC106, 0, 0, 0, 16'h0800, 16'h0000, 0, 16'd3, "hfl1");
        step(16'h002A, 16'hC005, 0, 0, 1, 16'hC005, 16'h002A, 0, 16'd3, "hfl2");

        // saturation of stall_cnt
        if_PC2 = 16'h0030; if_instr = 16'hC111; stall = 1'b1; flush = 1'b0;
        repeat (65540) @(posedge clk);
        #1;
        check_eq("sat.cnt",   32'(stall_cnt), 32'hFFFF);
        check_eq("sat.instr", 32'(id_instr), 32'hC005);
        step(16'h0032, 16'hC222, 0, 0, 1, 16'hC222, 16'h0032, 0, 16'hFFFF, "satrel");

        // asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("arst.pc2",   32'(id_PC2), 32'h0);
        check_eq("arst.instr", 32'(id_instr), 32'h0800);
        check_eq("arst.valid", 32'(id_valid), 32'h0);
        check_eq("arst.cnt",   32'(stall_cnt), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(16'h0040, 16'hC333, 0, 0, 1, 16'hC333, 16'h0040, 0, 16'd0, "post");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
